// File: rtl/parity_stream.sv
// parity_stream: streaming parity generator/checker with one registered
// output stage and full backpressure.
//
// Every accepted word produces one output word that carries:
// - the word's own parity bit
// - the running parity of its frame, including this word
// - its saturating 1-based position within the frame
// - an optional mismatch flag, set on the last word of the frame
//
// Frames are delimited by in_last. The parity sense (mode_odd) and the check
// enable (chk_en) are captured on the first word of a frame and held until the
// frame closes.
//
// Handshake (valid/ready, both sides):
// - A transfer happens on a rising clk edge where valid and ready are both 1.
// - A producer that raises valid keeps valid and its payload stable until that
//   transfer happens.
// - in_ready = ~out_valid | out_ready. The block can take a new word in the
//   same cycle that the held word drains, so a full-rate stream sees no bubble.
//
// Ports:
//   clk, rst       rising-edge clock; asynchronous active-high reset
//   mode_odd       1 = odd parity, 0 = even (sampled on the first word)
//   chk_en         1 = compare in_par on the last word (sampled with mode_odd)
//   in_valid/in_ready/in_data/in_last/in_par   input word stream
//   out_valid/out_ready                        output handshake
//   out_data/out_last                          registered copies of the input
//   out_wpar       parity bit of this word alone
//   out_fpar       frame parity over all words so far, including this one
//   out_err        frame parity mismatch on the last word (checking enabled)
//   out_cnt        1-based word index within the frame, saturating
//   state_dbg      current frame state (0 = IDLE, 1 = FRAME)
module parity_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_odd,
  input  logic             chk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wpar,
  output logic             out_last,
  output logic             out_fpar,
  output logic             out_err,
  output logic [CNT_W-1:0] out_cnt,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Per-frame context: latched parity mode, check enable, running parity of
  // the data bits (mode not yet applied), and the word counter.
  logic             mode_q;
  logic             chk_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             first;
  logic             m_eff;
  logic             c_eff;
  logic             word_par;
  logic             acc_nxt;
  logic             fpar_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    first     = (state == IDLE);
    word_par  = ^in_data;
    // The first word of a frame uses the live mode/check inputs; later words
    // use the values captured when the frame opened.
    m_eff     = first ? mode_odd : mode_q;
    c_eff     = first ? chk_en : chk_q;
    acc_nxt   = first ? word_par : (acc_q ^ word_par);
    if (first) begin
      cnt_nxt = CNT_W'(1);
    end else if (&cnt_q) begin
      cnt_nxt = cnt_q;
    end else begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
    fpar_nxt  = acc_nxt ^ m_eff;
    err_nxt   = in_last & c_eff & (in_par != fpar_nxt);
    if (accept) begin
      state_nxt = in_last ? IDLE : FRAME;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      chk_q  <= 1'b0;
      acc_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_nxt;
      if (first) begin
        mode_q <= mode_odd;
        chk_q  <= chk_en;
      end
    end
  end

  // Output stage: load on accept (which also covers a simultaneous drain);
  // otherwise a drain only clears out_valid and the payload holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_wpar  <= 1'b0;
      out_last  <= 1'b0;
      out_fpar  <= 1'b0;
      out_err   <= 1'b0;
      out_cnt   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_wpar  <= word_par ^ m_eff;
      out_last  <= in_last;
      out_fpar  <= fpar_nxt;
      out_err   <= err_nxt;
      out_cnt   <= cnt_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/parity_stream.md
Name: parity_stream

Overview:
- Streaming parity generator/checker: accepts WIDTH-bit words over a valid/ready handshake.
- Computes a per-word parity bit and a running frame parity across a multi-word frame delimited by in_last.
- Optionally checks a received frame parity bit.
- Sits between a data source and a serial/link framer; one registered output stage with full backpressure.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- CNT_W, 8, width of the per-frame word counter (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mode_odd  input  1  1 = odd parity, 0 = even parity; sampled on the first word of each frame
- chk_en  input  1  1 = check in_par on the last word; sampled with mode_odd
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  input word
- in_last  input  1  word is the last of its frame
- in_par  input  1  received frame parity bit, meaningful only when in_last=1
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accepts the word
- out_data  output  WIDTH  registered copy of in_data
- out_wpar  output  1  parity bit for this word alone
- out_last  output  1  registered in_last
- out_fpar  output  1  frame parity over all words so far, including this one
- out_err  output  1  parity mismatch; asserted only on the last word when checking is enabled
- out_cnt  output  CNT_W  1-based index of this word within its frame, saturating

Behaviour:
- Reset (async, rst=1): all outputs 0; state=IDLE; accumulator=0; counter=0; latched mode=even; latched chk=0.
- in_ready = ~out_valid | out_ready (combinational). Accept = in_valid & in_ready. Latency is 1 cycle from accept to out_valid.
- On accept:
  - out_valid=1.
  - out_data/out_last load from the input.
  - out_wpar = ^in_data XOR m, where m is the mode in effect for the frame.
  - Even mode: data plus parity bit has an even count of ones. Odd mode: data plus parity bit has an odd count of ones.
- Handshake:
  - If out_valid & out_ready and no accept, out_valid->0 next cycle.
  - If out_valid & ~out_ready, all out_* hold stable.
  - Simultaneous drain and accept replaces the contents with no bubble.
- FSM states: IDLE (no frame open) and FRAME (frame open).
- IDLE, accept:
  - m = mode_odd and c = chk_en are latched for the frame and used for this word.
  - acc = ^in_data; cnt = 1.
  - Next state is FRAME if in_last=0, otherwise IDLE.
- FRAME, accept:
  - m and c unchanged (mode_odd/chk_en are ignored mid-frame).
  - acc = acc ^ (^in_data); cnt = cnt+1, saturating at 2^CNT_W-1.
  - in_last=1 -> IDLE.
- Outputs on accept:
  - out_fpar = acc_new ^ m.
  - out_cnt = cnt_new.
  - out_err = in_last & c & (in_par != out_fpar); otherwise 0.
- Single-word frame (IDLE and in_last=1 together) is legal: cnt=1, fpar=wpar.
- No accept: state, acc and cnt hold (in_valid low or backpressure).
- rst mid-frame: the frame is discarded, any pending output is dropped, and the next accepted word starts a new frame.
- WIDTH=1: parity of the single bit; all rules unchanged.

Test Plan:
- Even mode, single word 8'hA5 with last=1, chk_en=0 -> one cycle later out_valid=1, out_data=A5, out_wpar=0, out_fpar=0, out_cnt=1, out_err=0.
- Odd mode, frame {8'h01, 8'h03, 8'h07} (last on 3rd), chk_en=1, in_par=1:
  - out_wpar sequence 0,1,0; out_fpar sequence 0,0,1; out_cnt 1,2,3.
  - out_err=0 on the 3rd word. Repeat with in_par=0 -> out_err=1 on the 3rd word only.
- mode_odd toggled mid-frame (even at word 1, odd at word 2), data 8'h01, 8'h01 -> both words use even mode: out_fpar 1 then 0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1:
  - in_ready=0 after the first accept; out_* stable; no word lost or duplicated.
  - Then out_ready=1 with continuous input -> one word per cycle.
- CNT_W=2, 5-word frame -> out_cnt 1,2,3,3,3; fpar still correct.
- Assert rst after word 2 of a 4-word frame -> outputs 0 immediately. A new frame 8'hFF (last) in odd mode -> out_fpar=1, out_cnt=1.
